exception_unit: RTL and testbench

- Trap controller directly upstream of the machine-mode CSR file.
- Collects synchronous exception flags and async interrupt lines from the pipeline, prioritises them, and computes next mepc/mcause/mtval/mstatus/mip.
- Drives the CSR file's exception write/interrupt strobes, MRET handling and return-address select.
- Flushes and redirects fetch through a small FSM.

---
 rtl/exception_unit_pkg.sv | 47 ++++
 rtl/exception_unit_if.sv | 57 +++++
 rtl/exception_unit_exc_cause_encoder.sv | 55 +++++
 rtl/exception_unit.sv | 203 ++++++++++++++++++++
 tb/tb_exception_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/exception_unit_pkg.sv
// Shared constants, FSM state type and mstatus update helpers for the trap controller.
package exception_unit_pkg;

  localparam logic [3:0] CODE_INST_MISALIGN  = 4'd0;
  localparam logic [3:0] CODE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CODE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CODE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CODE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CODE_ECALL          = 4'd11;
  localparam logic [3:0] CODE_MSI            = 4'd3;
  localparam logic [3:0] CODE_MTI            = 4'd7;
  localparam logic [3:0] CODE_MEI            = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIP_MSI = 3;
  localparam int MIP_MTI = 7;
  localparam int MIP_MEI = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/exception_unit_if.sv
// Commit-stage / CSR-file bus of the trap controller; names are from the controller's view.
interface exception_unit_if;

  logic        valid_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [31:0] fault_addr_i;
  logic        e_inst_misalign_i;
  logic        e_illegal_i;
  logic        e_illegal_csr_i;
  logic        e_ecall_i;
  logic        e_ebreak_i;
  logic        e_load_misalign_i;
  logic        e_store_misalign_i;
  logic        is_mret_i;
  logic        irq_sw_i;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] mepc_i;
  logic [31:0] mcause_i;
  logic [31:0] mtval_i;

  logic        we_exc_o;
  logic        is_int_o;
  logic [31:0] mcause_o;
  logic [31:0] mepc_o;
  logic [31:0] mtval_o;
  logic [31:0] mstatus_o;
  logic [31:0] mip_o;
  logic        sel_exc_nret_o;
  logic        flush_o;
  logic        redirect_o;
  logic        busy_o;

  modport slave (
    input  valid_i, pc_i, inst_i, fault_addr_i,
    input  e_inst_misalign_i, e_illegal_i, e_illegal_csr_i, e_ecall_i,
    input  e_ebreak_i, e_load_misalign_i, e_store_misalign_i, is_mret_i,
    input  irq_sw_i, irq_timer_i, irq_ext_i,
    input  mstatus_i, mie_i, mepc_i, mcause_i, mtval_i,
    output we_exc_o, is_int_o, mcause_o, mepc_o, mtval_o, mstatus_o, mip_o,
    output sel_exc_nret_o, flush_o, redirect_o, busy_o
  );

  modport master (
    output valid_i, pc_i, inst_i, fault_addr_i,
    output e_inst_misalign_i, e_illegal_i, e_illegal_csr_i, e_ecall_i,
    output e_ebreak_i, e_load_misalign_i, e_store_misalign_i, is_mret_i,
    output irq_sw_i, irq_timer_i, irq_ext_i,
    output mstatus_i, mie_i, mepc_i, mcause_i, mtval_i,
    input  we_exc_o, is_int_o, mcause_o, mepc_o, mtval_o, mstatus_o, mip_o,
    input  sel_exc_nret_o, flush_o, redirect_o, busy_o
  );

endinterface

// File: rtl/exception_unit_exc_cause_encoder.sv
// Priority encoder: synchronous exceptions first, then enabled interrupts (MEI > MSI > MTI).
module exc_cause_encoder
  import exception_unit_pkg::*;
(
  input  logic        i_illegal,
  input  logic        i_illegal_csr,
  input  logic        i_inst_misalign,
  input  logic        i_ecall,
  input  logic        i_ebreak,
  input  logic        i_load_misalign,
  input  logic        i_store_misalign,
  input  logic [31:0] i_irq_pend,
  output logic        o_valid,
  output logic        o_is_int,
  output logic [3:0]  o_code
);

  always_comb begin
    o_valid  = 1'b0;
    o_is_int = 1'b0;
    o_code   = 4'd0;
    if (i_illegal || i_illegal_csr) begin
      o_valid = 1'b1;
      o_code  = CODE_ILLEGAL;
    end else if (i_inst_misalign) begin
      o_valid = 1'b1;
      o_code  = CODE_INST_MISALIGN;
    end else if (i_ecall) begin
      o_valid = 1'b1;
      o_code  = CODE_ECALL;
    end else if (i_ebreak) begin
      o_valid = 1'b1;
      o_code  = CODE_BREAKPOINT;
    end else if (i_load_misalign) begin
      o_valid = 1'b1;
      o_code  = CODE_LOAD_MISALIGN;
    end else if (i_store_misalign) begin
      o_valid = 1'b1;
      o_code  = CODE_STORE_MISALIGN;
    end else if (|i_irq_pend) begin
      o_valid  = 1'b1;
      o_is_int = 1'b1;
      if (i_irq_pend[MIP_MEI]) begin
        o_code = CODE_MEI;
      end else if (i_irq_pend[MIP_MSI]) begin
        o_code = CODE_MSI;
      end else begin
        o_code = CODE_MTI;
      end
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/exception_unit.sv
// Machine-mode trap controller: prioritises events, computes next CSR values, flushes and redirects fetch.
// EXC_IRQ_SYNC_EN: when defined, interrupt lines pass a 2-flop synchroniser instead of a single register.
module exception_unit
  import exception_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit MTVAL_EN = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  exception_unit_if.slave bus
);

  logic [2:0]      w_irq_raw;
  logic [2:0]      r_irq_sync;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_irq_pend;
  logic            w_enc_valid;
  logic            w_enc_is_int;
  logic [3:0]      w_enc_code;
  logic            w_take_trap;
  logic            w_take_mret;
  logic [XLEN-1:0] w_mepc_nxt;
  logic [XLEN-1:0] w_mcause_nxt;
  logic [XLEN-1:0] w_mtval_nxt;
  logic [XLEN-1:0] w_mstatus_nxt;
  logic [XLEN-1:0] w_mtval_exc;

  state_e          r_state;
  logic            r_we_exc;
  logic            r_is_int;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_mstatus;
  logic            r_sel_exc_nret;
  logic            r_flush;
  logic            r_redirect;
  logic            r_busy;

  assign w_irq_raw = {bus.irq_ext_i, bus.irq_timer_i, bus.irq_sw_i};

`ifdef EXC_IRQ_SYNC_EN
  logic [2:0] r_irq_meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_meta <= 3'b000;
      r_irq_sync <= 3'b000;
    end else begin
      r_irq_meta <= w_irq_raw;
      r_irq_sync <= r_irq_meta;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_sync <= 3'b000;
    end else begin
      r_irq_sync <= w_irq_raw;
    end
  end
`endif

  assign w_mip = {20'b0, r_irq_sync[2], 3'b000, r_irq_sync[1], 3'b000, r_irq_sync[0], 3'b000};
  assign w_irq_pend = w_mip & bus.mie_i & {XLEN{bus.mstatus_i[MSTATUS_MIE]}};

  exc_cause_encoder u_enc (
    .i_illegal        (bus.e_illegal_i),
    .i_illegal_csr    (bus.e_illegal_csr_i),
    .i_inst_misalign  (bus.e_inst_misalign_i),
    .i_ecall          (bus.e_ecall_i),
    .i_ebreak         (bus.e_ebreak_i),
    .i_load_misalign  (bus.e_load_misalign_i),
    .i_store_misalign (bus.e_store_misalign_i),
    .i_irq_pend       (w_irq_pend),
    .o_valid          (w_enc_valid),
    .o_is_int         (w_enc_is_int),
    .o_code           (w_enc_code)
  );

  // An exception beats MRET, and MRET beats a pending interrupt so it stays pending.
  always_comb begin
    w_take_trap = 1'b0;
    w_take_mret = 1'b0;
    if (bus.valid_i) begin
      if (w_enc_valid && !w_enc_is_int) begin
        w_take_trap = 1'b1;
      end else if (bus.is_mret_i) begin
        w_take_mret = 1'b1;
      end else if (w_enc_valid) begin
        w_take_trap = 1'b1;
      end else begin
        w_take_trap = 1'b0;
      end
    end else begin
      w_take_trap = 1'b0;
    end
  end

  always_comb begin
    w_mtval_exc = '0;
    case (w_enc_code)
      CODE_ILLEGAL:        w_mtval_exc = bus.inst_i;
      CODE_INST_MISALIGN,
      CODE_LOAD_MISALIGN,
      CODE_STORE_MISALIGN: w_mtval_exc = bus.fault_addr_i;
      CODE_BREAKPOINT:     w_mtval_exc = bus.pc_i;
      default:             w_mtval_exc = '0;
    endcase
  end

  always_comb begin
    w_mepc_nxt    = '0;
    w_mcause_nxt  = '0;
    w_mtval_nxt   = '0;
    w_mstatus_nxt = '0;
    if (w_take_mret) begin
      w_mepc_nxt    = bus.mepc_i;
      w_mcause_nxt  = bus.mcause_i;
      w_mtval_nxt   = bus.mtval_i;
      w_mstatus_nxt = mret_mstatus(bus.mstatus_i);
    end else begin
      w_mepc_nxt    = {bus.pc_i[XLEN-1:2], 2'b00};
      w_mcause_nxt  = {w_enc_is_int, 27'b0, w_enc_code};
      if (MTVAL_EN && !w_enc_is_int) begin
        w_mtval_nxt = w_mtval_exc;
      end else begin
        w_mtval_nxt = '0;
      end
      w_mstatus_nxt = trap_mstatus(bus.mstatus_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_we_exc       <= 1'b0;
      r_is_int       <= 1'b0;
      r_mcause       <= '0;
      r_mepc         <= '0;
      r_mtval        <= '0;
      r_mstatus      <= '0;
      r_sel_exc_nret <= 1'b0;
      r_flush        <= 1'b0;
      r_redirect     <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_we_exc   <= 1'b0;
      r_is_int   <= 1'b0;
      r_redirect <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take_trap || w_take_mret) begin
            r_state        <= ST_COMMIT;
            r_we_exc       <= 1'b1;
            r_is_int       <= w_take_trap && w_enc_is_int;
            r_mcause       <= w_mcause_nxt;
            r_mepc         <= w_mepc_nxt;
            r_mtval        <= w_mtval_nxt;
            r_mstatus      <= w_mstatus_nxt;
            r_sel_exc_nret <= w_take_mret;
            r_flush        <= 1'b1;
            r_busy         <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_COMMIT: begin
          r_state    <= ST_REDIRECT;
          r_redirect <= 1'b1;
          r_flush    <= 1'b1;
          r_busy     <= 1'b1;
        end
        ST_REDIRECT: begin
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.we_exc_o       = r_we_exc;
  assign bus.is_int_o       = r_is_int;
  assign bus.mcause_o       = r_mcause;
  assign bus.mepc_o         = r_mepc;
  assign bus.mtval_o        = r_mtval;
  assign bus.mstatus_o      = r_mstatus;
  assign bus.mip_o          = w_mip;
  assign bus.sel_exc_nret_o = r_sel_exc_nret;
  assign bus.flush_o        = r_flush;
  assign bus.redirect_o     = r_redirect;
  assign bus.busy_o         = r_busy;

endmodule

// File: tb/tb_exception_unit.sv
// Directed-vector bench for exception_unit with hand-computed CSR values.
module tb_exception_unit;

`ifdef EXC_IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  exception_unit_if u_if ();

  exception_unit #(.XLEN(32), .MTVAL_EN(1'b1)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    u_if.valid_i            = 1'b0;
    u_if.pc_i               = 32'h0;
    u_if.inst_i             = 32'h0;
    u_if.fault_addr_i       = 32'h0;
    u_if.e_inst_misalign_i  = 1'b0;
    u_if.e_illegal_i        = 1'b0;
    u_if.e_illegal_csr_i    = 1'b0;
    u_if.e_ecall_i          = 1'b0;
    u_if.e_ebreak_i         = 1'b0;
    u_if.e_load_misalign_i  = 1'b0;
    u_if.e_store_misalign_i = 1'b0;
    u_if.is_mret_i          = 1'b0;
    u_if.irq_sw_i           = 1'b0;
    u_if.irq_timer_i        = 1'b0;
    u_if.irq_ext_i          = 1'b0;
    u_if.mstatus_i          = 32'h0;
    u_if.mie_i              = 32'h0;
    u_if.mepc_i             = 32'h0;
    u_if.mcause_i           = 32'h0;
    u_if.mtval_i            = 32'h0;
  endtask

  // Checks one trap's COMMIT cycle (called one edge after the event), then walks REDIRECT and back to IDLE.
  task automatic expect_trap(input string tag, input logic [31:0] cause, input logic [31:0] epc,
                             input logic [31:0] tval, input logic [31:0] status, input logic is_int,
                             input logic sel);
    check_val({tag, " we_exc"}, {31'b0, u_if.we_exc_o}, 32'h1);
    check_val({tag, " is_int"}, {31'b0, u_if.is_int_o}, {31'b0, is_int});
    check_val({tag, " mcause"}, u_if.mcause_o, cause);
    check_val({tag, " mepc"}, u_if.mepc_o, epc);
    check_val({tag, " mtval"}, u_if.mtval_o, tval);
    check_val({tag, " mstatus"}, u_if.mstatus_o, status);
    check_val({tag, " commit flush/busy/redir"},
              {29'b0, u_if.flush_o, u_if.busy_o, u_if.redirect_o}, 32'h6);
    clear_inputs();
    tick();
    check_val({tag, " redirect we/red/flush"},
              {29'b0, u_if.we_exc_o, u_if.redirect_o, u_if.flush_o}, 32'h3);
    check_val({tag, " sel_exc_nret"}, {31'b0, u_if.sel_exc_nret_o}, {31'b0, sel});
    tick();
    check_val({tag, " idle red/flush/busy"},
              {29'b0, u_if.redirect_o, u_if.flush_o, u_if.busy_o}, 32'h0);
  endtask

  task automatic irq_trap(input string tag, input logic [2:0] lines, input logic [31:0] exp_mip,
                          input logic [31:0] exp_cause, input logic [31:0] pc);
    u_if.mstatus_i   = 32'h8;
    u_if.mie_i       = 32'h888;
    u_if.irq_ext_i   = lines[2];
    u_if.irq_timer_i = lines[1];
    u_if.irq_sw_i    = lines[0];
    for (int i = 0; i < SYNC_LAT; i++) tick();
    check_val({tag, " mip"}, u_if.mip_o, exp_mip);
    u_if.valid_i = 1'b1;
    u_if.pc_i    = pc;
    tick();
    expect_trap(tag, exp_cause, pc, 32'h0, 32'h1880, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_val("reset strobes", {27'b0, u_if.we_exc_o, u_if.is_int_o, u_if.flush_o, u_if.redirect_o,
              u_if.busy_o}, 32'h0);
    check_val("reset mip", u_if.mip_o, 32'h0);
    check_val("reset mcause", u_if.mcause_o, 32'h0);

    // ecall
    u_if.valid_i   = 1'b1;
    u_if.pc_i      = 32'h100;
    u_if.mstatus_i = 32'h8;
    u_if.e_ecall_i = 1'b1;
    tick();
    expect_trap("ecall", 32'hB, 32'h100, 32'h0, 32'h1880, 1'b0, 1'b0);

    // illegal beats ecall
    u_if.valid_i     = 1'b1;
    u_if.pc_i        = 32'h104;
    u_if.inst_i      = 32'hFFFF_FFFF;
    u_if.mstatus_i   = 32'h8;
    u_if.e_illegal_i = 1'b1;
    u_if.e_ecall_i   = 1'b1;
    tick();
    expect_trap("illegal", 32'h2, 32'h104, 32'hFFFF_FFFF, 32'h1880, 1'b0, 1'b0);

    // ebreak at unaligned pc: mepc masked, mtval keeps raw pc
    u_if.valid_i    = 1'b1;
    u_if.pc_i       = 32'h10A;
    u_if.e_ebreak_i = 1'b1;
    tick();
    expect_trap("ebreak", 32'h3, 32'h108, 32'h10A, 32'h1800, 1'b0, 1'b0);

    // store misaligned
    u_if.valid_i            = 1'b1;
    u_if.pc_i               = 32'h120;
    u_if.fault_addr_i       = 32'h1003;
    u_if.mstatus_i          = 32'h8;
    u_if.e_store_misalign_i = 1'b1;
    tick();
    expect_trap("store_mis", 32'h6, 32'h120, 32'h1003, 32'h1880, 1'b0, 1'b0);

    // timer interrupt, waiting for a valid instruction first
    u_if.mie_i       = 32'h80;
    u_if.mstatus_i   = 32'h8;
    u_if.irq_timer_i = 1'b1;
    for (int i = 0; i < SYNC_LAT - 1; i++) tick();
    check_val("mtip latency", u_if.mip_o, 32'h0);
    tick();
    check_val("mtip mip", u_if.mip_o, 32'h80);
    tick();
    check_val("irq waits valid", {30'b0, u_if.we_exc_o, u_if.busy_o}, 32'h0);
    u_if.valid_i = 1'b1;
    u_if.pc_i    = 32'h200;
    tick();
    expect_trap("mti", 32'h8000_0007, 32'h200, 32'h0, 32'h1880, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // timer pending but MIE clear: no trap
    u_if.mie_i       = 32'h80;
    u_if.mstatus_i   = 32'h0;
    u_if.irq_timer_i = 1'b1;
    u_if.valid_i     = 1'b1;
    u_if.pc_i        = 32'h300;
    for (int i = 0; i < SYNC_LAT + 2; i++) tick();
    check_val("mie0 mip", u_if.mip_o, 32'h80);
    check_val("mie0 no trap", {30'b0, u_if.we_exc_o, u_if.busy_o}, 32'h0);
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();

    // MRET
    u_if.valid_i   = 1'b1;
    u_if.pc_i      = 32'h400;
    u_if.is_mret_i = 1'b1;
    u_if.mstatus_i = 32'h1880;
    u_if.mepc_i    = 32'h104;
    u_if.mcause_i  = 32'hB;
    u_if.mtval_i   = 32'h55;
    tick();
    expect_trap("mret", 32'hB, 32'h104, 32'h55, 32'h1888, 1'b0, 1'b1);

    // MRET plus load misaligned: exception wins
    u_if.valid_i           = 1'b1;
    u_if.pc_i              = 32'h500;
    u_if.is_mret_i         = 1'b1;
    u_if.mstatus_i         = 32'h1880;
    u_if.mepc_i            = 32'h104;
    u_if.fault_addr_i      = 32'h2002;
    u_if.e_load_misalign_i = 1'b1;
    tick();
    expect_trap("mret+load_mis", 32'h4, 32'h500, 32'h2002, 32'h1800, 1'b0, 1'b0);

    irq_trap("mei>msi", 3'b101, 32'h808, 32'h8000_000B, 32'h600);
    irq_trap("msi>mti", 3'b011, 32'h088, 32'h8000_0003, 32'h700);

    // reset during COMMIT
    u_if.valid_i   = 1'b1;
    u_if.pc_i      = 32'h800;
    u_if.mstatus_i = 32'h8;
    u_if.e_ecall_i = 1'b1;
    tick();
    check_val("pre-reset we_exc", {31'b0, u_if.we_exc_o}, 32'h1);
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst commit strobes", {26'b0, u_if.we_exc_o, u_if.is_int_o, u_if.flush_o,
              u_if.redirect_o, u_if.busy_o, u_if.sel_exc_nret_o}, 32'h0);
    check_val("rst commit mcause", u_if.mcause_o, 32'h0);
    check_val("rst commit mepc", u_if.mepc_o, 32'h0);
    check_val("rst commit mstatus", u_if.mstatus_o, 32'h0);
    tick();
    check_val("post-rst no redirect", {29'b0, u_if.redirect_o, u_if.flush_o, u_if.busy_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
